// File: rtl/spi_pkg.sv
// Shared SPI front-end types and command byte constants used by the SPI slave and control stage.
package spi_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } spi_state_t;

    localparam logic [BYTE_W-1:0] CONF_WR = 8'h2a;
    localparam logic [BYTE_W-1:0] INFO_RD = 8'h3a;
    localparam logic [BYTE_W-1:0] DATA_RD = 8'h3b;

endpackage

// File: rtl/spi_slave_pin_sync.sv
// Multi-stage synchroniser for a bundle of asynchronous pins; the low EDGE_W bits also get
// registered rise/fall strobes that line up with level_o.
module pin_sync #(
    parameter int unsigned             SYNC_STAGES = 2,
    parameter int unsigned             WIDTH       = 1,
    parameter int unsigned             EDGE_W      = 1,
    parameter logic [WIDTH-1:0]        RST_VAL     = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [WIDTH-1:0]  pin_i,
    output logic [WIDTH-1:0]  level_o,
    output logic [EDGE_W-1:0] rise_o,
    output logic [EDGE_W-1:0] fall_o
);

    logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]  sync_d [SYNC_STAGES];
    logic [WIDTH-1:0]  dly_q, dly_d;
    logic [EDGE_W-1:0] rise_q, rise_d;
    logic [EDGE_W-1:0] fall_q, fall_d;

    // dly_q is one stage past the chain so edges and level describe the same sample
    always_comb begin
        sync_d[0] = pin_i;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        dly_d  = sync_q[SYNC_STAGES-1];
        rise_d = sync_q[SYNC_STAGES-1][EDGE_W-1:0] & ~dly_q[EDGE_W-1:0];
        fall_d = ~sync_q[SYNC_STAGES-1][EDGE_W-1:0] & dly_q[EDGE_W-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= RST_VAL;
            end
            dly_q  <= RST_VAL;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            dly_q  <= dly_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign level_o = dly_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave: oversampled pins, MOSI byte deserialiser with D/C capture.
// Define SPI_SLAVE_TX_EN to build the MISO readback serialiser.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              spi_sclk_i,
    input  logic              spi_cs_n_i,
    input  logic              spi_mosi_i,
    input  logic              spi_dc_i,
    output logic              spi_miso_o,
    output logic              byte_vld_o,
    output logic [BYTE_W-1:0] byte_data_o,
    output logic              dc_o,
    input  logic [BYTE_W-1:0] tx_data_i,
    output logic              tx_rd_o
);

    logic [3:0] pin_lvl;
    logic [1:0] pin_rise, pin_fall;
    logic       sclk_lvl, cs_n, mosi, dc;
    logic       sclk_rise, sclk_fall, cs_rise, cs_fall;

    // bit order {dc, mosi, cs_n, sclk}; only sclk and cs_n need edges
    pin_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .WIDTH       (4),
        .EDGE_W      (2),
        .RST_VAL     (4'b0010)
    ) u_pin_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .pin_i   ({spi_dc_i, spi_mosi_i, spi_cs_n_i, spi_sclk_i}),
        .level_o (pin_lvl),
        .rise_o  (pin_rise),
        .fall_o  (pin_fall)
    );

    assign {dc, mosi, cs_n, sclk_lvl} = pin_lvl;
    assign {cs_rise, sclk_rise}       = pin_rise;
    assign {cs_fall, sclk_fall}       = pin_fall;

    spi_state_t           state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]    rx_shift_q, rx_shift_d;
    logic                 byte_vld_q, byte_vld_d;
    logic [BYTE_W-1:0]    byte_data_q, byte_data_d;
    logic                 dc_q, dc_d;

    // cs_n high wins over everything, which also drops any partial byte
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        byte_vld_d  = 1'b0;
        byte_data_d = byte_data_q;
        dc_d        = dc_q;
        if (cs_n) begin
            state_d    = IDLE;
            bit_cnt_d  = '0;
            rx_shift_d = '0;
        end else begin
            case (state_q)
                IDLE:  if (cs_fall) state_d = LOAD;
                LOAD:  state_d = SHIFT;
                SHIFT: begin
                    if (sclk_rise) begin
                        rx_shift_d = {rx_shift_q[BYTE_W-2:0], mosi};
                        bit_cnt_d  = BIT_CNT_W'(bit_cnt_q + 1'b1);
                        if (bit_cnt_q == '1) begin
                            byte_vld_d  = 1'b1;
                            byte_data_d = {rx_shift_q[BYTE_W-2:0], mosi};
                            dc_d        = dc;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            byte_vld_q  <= 1'b0;
            byte_data_q <= '0;
            dc_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            byte_vld_q  <= byte_vld_d;
            byte_data_q <= byte_data_d;
            dc_q        <= dc_d;
        end
    end

    assign byte_vld_o  = byte_vld_q;
    assign byte_data_o = byte_data_q;
    assign dc_o        = dc_q;

`ifdef SPI_SLAVE_TX_EN
    logic [BYTE_W-1:0] tx_shift_q, tx_shift_d;
    logic              tx_rd_q, tx_rd_d;
    logic              miso_q, miso_d;
    logic              unused_sync;

    // tx_rd_o is high in the cycle tx_data_i is taken; the fall that closes a byte
    // (bit_cnt wrapped to 0) must not shift, or the fresh MSB would be lost
    always_comb begin
        tx_shift_d = tx_shift_q;
        tx_rd_d    = (state_d == LOAD) || byte_vld_d;
        if (tx_rd_q) begin
            tx_shift_d = tx_data_i;
        end else if (state_q == SHIFT && !cs_n && sclk_fall && bit_cnt_q != '0) begin
            tx_shift_d = {tx_shift_q[BYTE_W-2:0], 1'b0};
        end
        miso_d = (state_d != IDLE) && tx_shift_d[BYTE_W-1];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_shift_q <= '0;
            tx_rd_q    <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            tx_shift_q <= tx_shift_d;
            tx_rd_q    <= tx_rd_d;
            miso_q     <= miso_d;
        end
    end

    assign spi_miso_o  = miso_q;
    assign tx_rd_o     = tx_rd_q;
    assign unused_sync = ^{sclk_lvl, cs_rise};
`else
    logic unused_sync;

    assign spi_miso_o  = 1'b0;
    assign tx_rd_o     = 1'b0;
    assign unused_sync = ^{sclk_lvl, cs_rise, sclk_fall, tx_data_i};
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed scoreboard bench for spi_slave: byte strobes, latency, abort, reset and MISO readback.
module tb_spi_slave;
    import spi_pkg::*;

    localparam int unsigned SYNC = 2;
    localparam int unsigned LAT  = SYNC + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0, spi_dc = 1'b0;
    logic       spi_miso, byte_vld, dc_out, tx_rd;
    logic [7:0] byte_data;
    logic [7:0] tx_data = 8'h00;

    spi_slave #(.SYNC_STAGES(SYNC)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .spi_sclk_i  (spi_sclk),
        .spi_cs_n_i  (spi_cs_n),
        .spi_mosi_i  (spi_mosi),
        .spi_dc_i    (spi_dc),
        .spi_miso_o  (spi_miso),
        .byte_vld_o  (byte_vld),
        .byte_data_o (byte_data),
        .dc_o        (dc_out),
        .tx_data_i   (tx_data),
        .tx_rd_o     (tx_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        dc;
        int unsigned cyc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned n_vld = 0;
    int unsigned tx_rd_cnt = 0;
    logic        vld_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every strobe must match the oldest pending byte, one cycle wide, fixed latency
    always @(negedge clk) begin
        exp_t e;
        if (tx_rd === 1'b1) tx_rd_cnt++;
        if (byte_vld === 1'b1) begin
            n_vld++;
            check("vld_width", 32'(vld_prev), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe_data", 32'(byte_data), 32'hffff_ffff);
            end else begin
                e = exp_q.pop_front();
                check("byte_data", 32'(byte_data), 32'(e.data));
                check("byte_dc", 32'(dc_out), 32'(e.dc));
                check("latency", 32'(cyc - e.cyc), 32'(LAT));
            end
        end
        vld_prev = byte_vld;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // drives the top nbits of d, MSB first; only a full byte is expected to strobe
    task automatic spi_bits(input logic [7:0] d, input int nbits, input logic dc_v, input int half,
                            input logic [7:0] tx_exp, input bit chk_miso);
        logic [7:0] miso_exp;
`ifdef SPI_SLAVE_TX_EN
        miso_exp = tx_exp;
`else
        miso_exp = 8'h00;
`endif
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_mosi = d[i];
            spi_dc   = dc_v;
            clks(half);
            spi_sclk = 1'b1;
            if (chk_miso) check("miso_bit", 32'(spi_miso), 32'(miso_exp[i]));
            if (i == 0) exp_q.push_back('{data: d, dc: dc_v, cyc: cyc});
            clks(half);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        clks(8);
    endtask

    task automatic cs_high();
        clks(4);
        spi_cs_n = 1'b1;
        clks(8);
    endtask

    int unsigned tx_base;

    initial begin
        // reset values
        clks(3);
        check("rst_vld", 32'(byte_vld), 32'd0);
        check("rst_data", 32'(byte_data), 32'd0);
        check("rst_dc", 32'(dc_out), 32'd0);
        check("rst_tx_rd", 32'(tx_rd), 32'd0);
        check("rst_miso", 32'(spi_miso), 32'd0);
        rst = 1'b0;
        clks(4);

        // command then three data bytes under one CS
        cs_low();
        spi_bits(CONF_WR, 8, 1'b0, 4, 8'h00, 1'b0);
        spi_bits(8'h11, 8, 1'b1, 4, 8'h00, 1'b0);
        spi_bits(8'h22, 8, 1'b1, 4, 8'h00, 1'b0);
        spi_bits(8'h33, 8, 1'b1, 4, 8'h00, 1'b0);
        cs_high();
        check("hold_data", 32'(byte_data), 32'h33);
        check("hold_dc", 32'(dc_out), 32'd1);

        // reset in the middle of a byte
        cs_low();
        spi_bits(CONF_WR, 4, 1'b1, 4, 8'h00, 1'b0);
        #3 rst = 1'b1;
        #1;
        check("midrst_vld", 32'(byte_vld), 32'd0);
        check("midrst_data", 32'(byte_data), 32'd0);
        check("midrst_dc", 32'(dc_out), 32'd0);
        check("midrst_tx_rd", 32'(tx_rd), 32'd0);
        check("midrst_miso", 32'(spi_miso), 32'd0);
        spi_cs_n = 1'b1;
        clks(3);
        rst = 1'b0;
        clks(5);
        cs_low();
        spi_bits(CONF_WR, 8, 1'b0, 4, 8'h00, 1'b0);
        cs_high();

        // abort a partial byte, then a clean one
        cs_low();
        spi_bits(8'hff, 5, 1'b1, 4, 8'h00, 1'b0);
        cs_high();
        cs_low();
        spi_bits(DATA_RD, 8, 1'b0, 4, 8'h00, 1'b0);
        cs_high();

        // minimum SCLK ratio, 16 continuous bits
        cs_low();
        spi_bits(8'ha5, 8, 1'b1, 2, 8'h00, 1'b0);
        spi_bits(8'h5a, 8, 1'b1, 2, 8'h00, 1'b0);
        cs_high();

        // MISO readback
        tx_base = tx_rd_cnt;
        tx_data = 8'hc3;
        cs_low();
        tx_data = 8'h96;
        spi_bits(INFO_RD, 8, 1'b0, 8, 8'hc3, 1'b1);
        spi_bits(8'h00, 8, 1'b1, 8, 8'h96, 1'b1);
        cs_high();
        check("idle_miso", 32'(spi_miso), 32'd0);
`ifdef SPI_SLAVE_TX_EN
        check("tx_rd_pulses", 32'(tx_rd_cnt - tx_base), 32'd3);
`else
        check("tx_rd_never", 32'(tx_rd_cnt), 32'd0);
`endif

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) clks(1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("strobe_count", 32'(n_vld), 32'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI mode-0 slave front end that oversamples the external SPI pins on clk_i.
- Deserialises MOSI into bytes and emits a one-cycle byte strobe with the byte value and the D/C pin level.
- Sits directly upstream of the command decoder/control stage, whose byte-valid, byte-data and dc inputs it drives.
- Optionally serialises a readback byte onto MISO.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on each SPI input pin (legal 2..4).

Ports:
- clk_i  input  1  system clock; must be at least 4x the SCLK frequency
- rst_i  input  1  asynchronous, active-high reset
- spi_sclk_i  input  1  SPI clock pin, CPOL=0
- spi_cs_n_i  input  1  chip select pin, active-low
- spi_mosi_i  input  1  serial data in, MSB first
- spi_dc_i  input  1  data/command pin (0 = command, 1 = data)
- spi_miso_o  output  1  serial data out, MSB first
- byte_vld_o  output  1  one-cycle pulse: byte_data_o and dc_o are valid
- byte_data_o  output  8  last received byte
- dc_o  output  1  D/C level captured with the byte
- tx_data_i  input  8  byte to transmit next
- tx_rd_o  output  1  one-cycle pulse: tx_data_i was consumed this cycle

Behaviour:
- Synchronisation
  - sclk, cs_n, mosi and dc each pass through SYNC_STAGES flops (reset value: sclk 0, cs_n 1, mosi 0, dc 0).
  - A further flop on sclk and cs_n provides edge detection: sclk_rise, sclk_fall, cs_fall, cs_rise.
  - All behaviour below is relative to the synchronised signals.
- Reset (rst_i high, asynchronous)
  - Outputs: byte_vld_o=0, byte_data_o=8'h00, dc_o=0, tx_rd_o=0, spi_miso_o=0.
  - bit_cnt=0, shift registers=0, FSM=IDLE.
- FSM states
  - IDLE: cs_n high.
  - LOAD: single cycle after cs_fall.
  - SHIFT: cs_n low.
- Transitions
  - IDLE->LOAD on cs_fall.
  - LOAD->SHIFT unconditionally.
  - Any state->IDLE when synchronised cs_n is high. This takes priority over every other event in the same cycle.
- Receive
  - In SHIFT, on sclk_rise: rx_shift <= {rx_shift[6:0], mosi}; bit_cnt <= bit_cnt+1 (3-bit, wraps 7->0).
  - On the sclk_rise where bit_cnt==7:
    - next cycle byte_vld_o=1, byte_data_o={rx_shift[6:0], mosi}, dc_o=synchronised dc sampled on that same edge;
    - byte_vld_o deasserts the following cycle;
    - byte_data_o and dc_o hold their value until the next byte completes.
- Latency: pin SCLK rising edge to byte_vld_o is SYNC_STAGES+2 clk_i cycles.
- Abort: cs_n rising with bit_cnt != 0 discards the partial byte (no byte_vld_o) and clears bit_cnt to 0.
- Simultaneous events: sclk_rise in the same cycle as cs_rise does not shift and does not strobe.
- Back-to-back bytes: no gap required; one byte_vld_o pulse per 8 rising edges.
- Mode checks: no error flag. SCLK high at cs_fall is not detected; it gives undefined framing for that transfer only.

Optional Feature:
- Macro: SPI_SLAVE_TX_EN.
- Defined:
  - In LOAD, and in the cycle after each byte completes (byte_vld_o cycle), tx_shift <= tx_data_i and tx_rd_o pulses for one cycle.
  - spi_miso_o = tx_shift[7] while in SHIFT/LOAD.
  - On each sclk_fall in SHIFT, tx_shift <= {tx_shift[6:0], 1'b0}.
  - spi_miso_o = 0 in IDLE.
  - Host constraint: CS-low to first SCLK rise is at least SYNC_STAGES+3 clk_i cycles.
- Undefined:
  - tx path is not built; spi_miso_o tied 0, tx_rd_o tied 0, tx_data_i unused.

Decomposition:
- Package spi_pkg holds:
  - localparam BYTE_W=8 and BIT_CNT_W=3;
  - typedef enum logic [1:0] spi_state_t {IDLE, LOAD, SHIFT};
  - the command byte constants shared with the control stage: CONF_WR=8'h2a, INFO_RD=8'h3a, DATA_RD=8'h3b.
- Sub-module: pin_sync (parameterised SYNC_STAGES, reset value; outputs level, rise and fall). Instantiated for sclk and cs_n; the level-only output is used for mosi and dc.

Test Plan:
- Reset mid-byte: assert rst_i after 4 SCLK bits -> outputs return to reset values immediately. After release, a full 8'h2a transfer yields exactly one byte_vld_o with byte_data_o=8'h2a.
- Command then data: dc=0 send 8'h2a, dc=1 send 8'h11, 8'h22, 8'h33 under one CS -> four byte_vld_o pulses, data 2a/11/22/33, dc_o 0/1/1/1, each pulse one cycle wide, SYNC_STAGES+2 cycles after the 8th SCLK rise.
- Abort: CS low, 5 SCLK bits of 8'hff, CS high, CS low, send 8'h3b -> exactly one byte_vld_o with 8'h3b (no 8'hf8/8'hff strobe).
- Minimum ratio: SCLK = clk_i/4, 16 continuous bits 8'ha5, 8'h5a -> two strobes, 8'ha5 then 8'h5a, no missed or duplicated edges.
- TX (SPI_SLAVE_TX_EN): tx_data_i=8'hc3 held at CS fall, then 8'h96 -> MISO bits 1,1,0,0,0,0,1,1 then 1,0,0,1,0,1,1,0, sampled on SCLK rise. tx_rd_o pulses once at LOAD and once per completed byte.
- TX disabled (SPI_SLAVE_TX_EN undefined): same stimulus -> spi_miso_o constant 0, tx_rd_o never asserts.
